tcdm_traffic_gen_synth: RTL and testbench
=========================================

// Module: tcdm_traffic_gen_synth
// PURPOSE
//  Synthesizable, DPI-free TCDM traffic generator for MemPool interconnect stress and latency characterisation.
//  One instance per core port; it drives one TCDM request/response channel (feeding snitch_addr_demux upstream).
//  Runtime modes are random, sequential-stride and hotspot. Injection rate is programmable and ROB IDs are tracked in a bitmap.
//  Built-in counters report issued and completed requests, latency sum and maximum, and stall cycles.
// PARAMETERS
//  NumOutstanding  8             max in-flight requests (ID pool size, >=2)
//  IdWidth         $clog2(NumOutstanding)  derived, do not override
//  AddrWidth       32            request address width
//  DataWidth       32            data width; StrbWidth = DataWidth/8 derived
//  CntWidth        32            width of cycle, stats and latency counters
//  LfsrSeed        32'hACE1_2345 LFSR seed, nonzero
// PORTS
//  clk_i             in   1          clock
//  rst_i             in   1          synchronous active-high reset
//  start_i           in   1          pulse: begin a run (accepted in IDLE/DONE only)
//  stop_i            in   1          pulse: stop issuing, drain outstanding
//  cfg_mode_i        in   2          0 random, 1 sequential, 2 hotspot, 3 = random
//  cfg_base_addr_i   in   AddrWidth  region base address
//  cfg_addr_mask_i   in   AddrWidth  offset mask (word aligned)
//  cfg_stride_i      in   AddrWidth  sequential-mode increment in bytes
//  cfg_rate_i        in   8          inject when lfsr[7:0] < rate; 0 = never
//  cfg_num_req_i     in   CntWidth   requests per run; 0 = unbounded
//  cfg_wen_i         in   1          1 = writes, 0 = reads
//  busy_o            out  1          state RUN or DRAIN
//  done_o            out  1          state DONE
//  req_valid_o       out  1          request valid
//  req_ready_i       in   1          request ready
//  req_addr_o        out  AddrWidth  request address
//  req_wen_o         out  1          write enable
//  req_wdata_o       out  DataWidth  write data
//  req_be_o          out  StrbWidth  byte enables
//  req_id_o          out  IdWidth    request ID
//  resp_valid_i      in   1          response valid
//  resp_ready_o      out  1          constant 1
//  resp_id_i         in   IdWidth    response ID
//  resp_rdata_i      in   DataWidth  read data (unused; ignored)
//  stat_issued_o     out  CntWidth   accepted requests this run
//  stat_completed_o  out  CntWidth   valid responses this run
//  stat_lat_sum_o    out  CntWidth   sum of latencies (wraps)
//  stat_lat_max_o    out  CntWidth   max latency
//  stat_stall_o      out  CntWidth   cycles with req_valid_o=1 and req_ready_i=0
//  err_o             out  1          sticky: response to a non-pending ID
// BEHAVIOUR
//  Reset (synchronous, rst_i=1 at clk_i edge):
//   state IDLE; all outputs 0 except resp_ready_o=1; pending bitmap and counters cleared; LFSR=LfsrSeed.
//  FSM states and transitions:
//   IDLE -start-> RUN.  DONE -start-> RUN.
//   RUN -> DRAIN when (cfg_num_req_i!=0 and issued==num_req) or stop_i.
//   DRAIN -> DONE when pending bitmap is all-zero and req_valid_o=0. stop_i in IDLE/DONE is ignored.
//  Start: clears stats, err_o, pending bitmap, sequential offset and cycle counter; reloads LFSR.
//  LFSR: 32-bit Galois, taps 0x80200003, advances every cycle in RUN.
//  Issue condition (RUN only): no held request or handshake this cycle, free ID exists, issue count (loaded) < num_req or
//   unbounded, lfsr[7:0] < cfg_rate_i. On issue the request register loads; req_valid_o rises next cycle.
//  Handshake: payload is stable while req_valid_o & !req_ready_i; a new request may load on the handshake cycle (back-to-back).
//  Config inputs are sampled at load; changing them mid-run affects later requests only.
//  ID allocation: lowest free bit of the pending bitmap, set at load. A response clears its bit.
//   A response and an allocation in the same cycle are legal; the allocation uses the pre-clear bitmap.
//  Free-ID exhaustion blocks issue only; stall counts only valid&!ready.
//  Address (low $clog2(StrbWidth) bits forced 0):
//   random     = base + (lfsr & mask)
//   sequential = base + (offset & mask); offset += stride on each handshake, wraps modulo 2^AddrWidth
//   hotspot    = base
//  Data: wdata = addr ^ 32'hA5A5A5A5 (replicated or truncated to DataWidth); be = all-ones if write, else 0.
//  Latency: cycle counter stamped per ID at handshake; on response lat = cycle - stamp (modulo 2^CntWidth).
//   lat_sum += lat (wraps); lat_max = max(lat_max, lat).
//  Unknown-ID response (bit not set): err_o set, response otherwise ignored, completed not incremented.
//  Counter widths: all wrap at 2^CntWidth except lat_max, which saturates.
//  Reset mid-run aborts the run, clears all state and drops in-flight IDs; later responses raise err_o after next start.
// TESTING
//  T1 reset: rst_i=1 for 2 cycles -> req_valid_o=0, busy_o=0, done_o=0, all stats 0, resp_ready_o=1.
//  T2 hotspot, rate=255, num_req=4, base=0x100, ready=1, 1-cycle response -> 4 requests to 0x100, IDs 0,1,2,3
//   (or reused low IDs); then DONE, issued=completed=4, lat_max=1.
//  T3 sequential, base=0x0, stride=4, mask=0xFF, num_req=70, writes -> addr 0x00,0x04..0xFC, wrap to 0x00;
//   wdata=addr^A5A5A5A5, be=all-ones.
//  T4 ready=0 for 10 cycles, then 1 -> payload held stable; stall=10. No responses -> after 8 loads issue halts with
//   NumOutstanding=8 IDs pending.
//  T5 response with ID never issued -> err_o=1 (sticky), completed unchanged; stop_i mid-run -> DRAIN, DONE after last response.
//  T6 rate=0 -> no requests in 1000 cycles; rst_i during RUN -> IDLE next cycle, req_valid_o=0.

Source files
------------

// File: rtl/tcdm_traffic_gen_synth_if.sv
// TCDM request/response channel between a traffic generator (master) and the
// interconnect port it stresses (slave).
//   req_valid/req_ready  request handshake
//   req_addr/req_wen     word-aligned address and write enable
//   req_wdata/req_be     write data and byte enables
//   req_id               transaction ID echoed back on resp_id
//   resp_valid/resp_ready response handshake (generator always ready)
//   resp_id/resp_rdata   response ID and read data
interface tcdm_traffic_gen_synth_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 3
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 req_wen;
  logic [DataWidth-1:0] req_wdata;
  logic [StrbWidth-1:0] req_be;
  logic [IdWidth-1:0]   req_id;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IdWidth-1:0]   resp_id;
  logic [DataWidth-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_be, req_id, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_be, req_id, resp_ready,
    output req_ready, resp_valid, resp_id, resp_rdata
  );
endinterface

// File: rtl/tcdm_traffic_gen_synth.sv
// Synthesizable TCDM traffic generator: issues random, strided or hotspot
// requests at an LFSR-gated rate, tracks in-flight IDs in a bitmap and
// collects issue/completion/latency/stall statistics for one core port.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, stop_i     run control pulses
//   cfg_*               mode, region, stride, rate, request count, direction
//   busy_o, done_o      RUN/DRAIN and DONE indications
//   stat_*              issued, completed, latency sum/max, stall cycles
//   err_o               sticky: response to a non-pending ID
//   tcdm                request/response channel (master side)
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing requests while the rate gate and free IDs allow
// DRAIN | no new requests, waiting for held request and responses
// DONE  | run finished, stats frozen, waiting for start
module tcdm_traffic_gen_synth #(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned CntWidth       = 32,
  parameter logic [31:0] LfsrSeed       = 32'hACE1_2345
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [AddrWidth-1:0] cfg_base_addr_i,
  input  logic [AddrWidth-1:0] cfg_addr_mask_i,
  input  logic [AddrWidth-1:0] cfg_stride_i,
  input  logic [7:0]           cfg_rate_i,
  input  logic [CntWidth-1:0]  cfg_num_req_i,
  input  logic                 cfg_wen_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  stat_issued_o,
  output logic [CntWidth-1:0]  stat_completed_o,
  output logic [CntWidth-1:0]  stat_lat_sum_o,
  output logic [CntWidth-1:0]  stat_lat_max_o,
  output logic [CntWidth-1:0]  stat_stall_o,
  output logic                 err_o,
  tcdm_traffic_gen_synth_if.master tcdm
);
  localparam int unsigned IdWidth   = $clog2(NumOutstanding);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                    state_q;
  logic [31:0]               lfsr_q;
  logic [NumOutstanding-1:0] pending_q;
  logic [AddrWidth-1:0]      seq_off_q;
  logic [CntWidth-1:0]       cycle_q;
  logic [CntWidth-1:0]       loaded_q;
  logic [CntWidth-1:0]       stamp_q [NumOutstanding];

  logic                      hs, load, id_free, loads_left, resp_hit, resp_miss;
  logic [IdWidth-1:0]        free_id;
  logic [NumOutstanding-1:0] set_mask, clr_mask;
  logic [AddrWidth-1:0]      off_eff, addr_raw, addr_new;
  logic [31:0]               wpat;
  logic [DataWidth-1:0]      wdata_new;
  logic [CntWidth-1:0]       lat;
  logic                      unused_rdata;

  assign unused_rdata = ^tcdm.resp_rdata;

  // Lowest free ID; scanning downwards lets the lowest index win.
  always_comb begin
    free_id = '0;
    id_free = 1'b0;
    for (int i = int'(NumOutstanding) - 1; i >= 0; i--) begin
      if (!pending_q[i]) begin
        free_id = IdWidth'(i);
        id_free = 1'b1;
      end
    end
  end

  assign hs         = tcdm.req_valid & tcdm.req_ready;
  assign loads_left = (cfg_num_req_i == '0) || (loaded_q < cfg_num_req_i);
  // stop_i also blocks the load in its own cycle so nothing new starts.
  assign load       = (state_q == RUN) && !stop_i && (!tcdm.req_valid || tcdm.req_ready) &&
                      id_free && loads_left && (lfsr_q[7:0] < cfg_rate_i);
  assign resp_hit   = tcdm.resp_valid &&  pending_q[tcdm.resp_id];
  assign resp_miss  = tcdm.resp_valid && !pending_q[tcdm.resp_id];
  assign lat        = cycle_q - stamp_q[tcdm.resp_id];

  // A back-to-back load sees the offset already advanced by this handshake.
  assign off_eff = hs ? seq_off_q + cfg_stride_i : seq_off_q;

  always_comb begin
    case (cfg_mode_i)
      2'd1:    addr_raw = cfg_base_addr_i + (off_eff & cfg_addr_mask_i);
      2'd2:    addr_raw = cfg_base_addr_i;
      default: addr_raw = cfg_base_addr_i + (AddrWidth'(lfsr_q) & cfg_addr_mask_i);
    endcase
  end

  assign addr_new = addr_raw & AlignMask;
  assign wpat     = 32'(addr_new) ^ 32'hA5A5_A5A5;

  always_comb begin
    wdata_new = '0;
    for (int i = 0; i < int'(DataWidth); i++) wdata_new[i] = wpat[i % 32];
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (load)     set_mask[free_id]      = 1'b1;
    if (resp_hit) clr_mask[tcdm.resp_id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      lfsr_q           <= LfsrSeed;
      pending_q        <= '0;
      seq_off_q        <= '0;
      cycle_q          <= '0;
      loaded_q         <= '0;
      stat_issued_o    <= '0;
      stat_completed_o <= '0;
      stat_lat_sum_o   <= '0;
      stat_lat_max_o   <= '0;
      stat_stall_o     <= '0;
      err_o            <= 1'b0;
      tcdm.req_valid   <= 1'b0;
      tcdm.req_addr    <= '0;
      tcdm.req_wen     <= 1'b0;
      tcdm.req_wdata   <= '0;
      tcdm.req_be      <= '0;
      tcdm.req_id      <= '0;
      tcdm.resp_ready  <= 1'b1;
    end else begin
      tcdm.resp_ready <= 1'b1;
      pending_q       <= (pending_q & ~clr_mask) | set_mask;

      if (hs) begin
        tcdm.req_valid          <= 1'b0;
        stat_issued_o           <= stat_issued_o + CntWidth'(1);
        stamp_q[tcdm.req_id]    <= cycle_q;
        seq_off_q               <= seq_off_q + cfg_stride_i;
      end
      if (tcdm.req_valid && !tcdm.req_ready) stat_stall_o <= stat_stall_o + CntWidth'(1);
      if (resp_hit) begin
        stat_completed_o <= stat_completed_o + CntWidth'(1);
        stat_lat_sum_o   <= stat_lat_sum_o + lat;
        if (lat > stat_lat_max_o) stat_lat_max_o <= lat;
      end
      if (resp_miss) err_o <= 1'b1;

      if (load) begin
        tcdm.req_valid <= 1'b1;
        tcdm.req_addr  <= addr_new;
        tcdm.req_wen   <= cfg_wen_i;
        tcdm.req_wdata <= wdata_new;
        tcdm.req_be    <= {StrbWidth{cfg_wen_i}};
        tcdm.req_id    <= free_id;
        loaded_q       <= loaded_q + CntWidth'(1);
      end

      if (state_q == RUN || state_q == DRAIN) cycle_q <= cycle_q + CntWidth'(1);

      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q          <= RUN;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            lfsr_q           <= LfsrSeed;
            pending_q        <= '0;
            seq_off_q        <= '0;
            cycle_q          <= '0;
            loaded_q         <= '0;
            stat_issued_o    <= '0;
            stat_completed_o <= '0;
            stat_lat_sum_o   <= '0;
            stat_lat_max_o   <= '0;
            stat_stall_o     <= '0;
            err_o            <= 1'b0;
          end
        end
        RUN: begin
          lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
          if (((cfg_num_req_i != '0) && (stat_issued_o == cfg_num_req_i)) || stop_i)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if ((pending_q == '0) && !tcdm.req_valid) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tcdm_traffic_gen_synth.sv
module tb_tcdm_traffic_gen_synth;
  localparam int NumOut = 8;
  localparam int IdW    = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int CW     = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, stop_i, cfg_wen_i;
  logic [1:0]    cfg_mode_i;
  logic [AW-1:0] cfg_base_addr_i, cfg_addr_mask_i, cfg_stride_i;
  logic [7:0]    cfg_rate_i;
  logic [CW-1:0] cfg_num_req_i;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] stat_issued_o, stat_completed_o, stat_lat_sum_o, stat_lat_max_o, stat_stall_o;

  always #5 clk_i = ~clk_i;

  tcdm_traffic_gen_synth_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IdW)) bus ();

  tcdm_traffic_gen_synth #(
    .NumOutstanding(NumOut), .AddrWidth(AW), .DataWidth(DW), .CntWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .cfg_mode_i(cfg_mode_i), .cfg_base_addr_i(cfg_base_addr_i),
    .cfg_addr_mask_i(cfg_addr_mask_i), .cfg_stride_i(cfg_stride_i),
    .cfg_rate_i(cfg_rate_i), .cfg_num_req_i(cfg_num_req_i), .cfg_wen_i(cfg_wen_i),
    .busy_o(busy_o), .done_o(done_o),
    .stat_issued_o(stat_issued_o), .stat_completed_o(stat_completed_o),
    .stat_lat_sum_o(stat_lat_sum_o), .stat_lat_max_o(stat_lat_max_o),
    .stat_stall_o(stat_stall_o), .err_o(err_o), .tcdm(bus)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  int            hs_cnt;
  logic [NumOut-1:0] tb_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run();
    hs_cnt  = 0;
    tb_out  = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Per cycle: check any handshake against the bench's address model, then
  // optionally answer it one cycle later.
  task automatic run_cycles(input int n, input bit respond, input bit until_done);
    logic          hs;
    logic [IdW-1:0] hid;
    logic [31:0]   ea;
    for (int c = 0; c < n; c++) begin
      if (until_done && done_o) break;
      hs  = bus.req_valid && bus.req_ready;
      hid = bus.req_id;
      if (hs) begin
        case (cfg_mode_i)
          2'd1:    ea = cfg_base_addr_i + ((32'(hs_cnt) * cfg_stride_i) & cfg_addr_mask_i);
          2'd2:    ea = cfg_base_addr_i;
          default: ea = bus.req_addr;
        endcase
        ea[1:0] = 2'b00;
        if (cfg_mode_i == 2'd0) chk("addr_region", bus.req_addr & ~cfg_addr_mask_i, cfg_base_addr_i);
        else                    chk("addr", bus.req_addr, ea);
        chk("wdata", bus.req_wdata, ea ^ 32'hA5A5_A5A5);
        chk("be", bus.req_be, cfg_wen_i ? 4'hF : 4'h0);
        chk("wen", bus.req_wen, cfg_wen_i);
        chk("id_not_outstanding", tb_out[hid], 1'b0);
        tb_out[hid] = 1'b1;
        hs_cnt++;
      end
      tick();
      bus.resp_valid = respond && hs;
      bus.resp_id    = hid;
      if (respond && hs) tb_out[hid] = 1'b0;
    end
    if (bus.resp_valid) begin
      tick();
      bus.resp_valid = 1'b0;
    end
    if (until_done) chk("done_reached", done_o, 1'b1);
  endtask

  logic [31:0]    cap_addr, cap_wdata;
  logic [IdW-1:0] cap_id;
  int             vcnt;
  logic [IdW-1:0] drain_ids [7];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    cfg_mode_i = 2'd2; cfg_base_addr_i = '0; cfg_addr_mask_i = '0; cfg_stride_i = '0;
    cfg_rate_i = 8'd0; cfg_num_req_i = '0; cfg_wen_i = 1'b0;
    bus.req_ready = 1'b1; bus.resp_valid = 1'b0; bus.resp_id = '0; bus.resp_rdata = '0;

    // T1 reset
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_valid", bus.req_valid, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_resp_ready", bus.resp_ready, 1'b1);
    chk("rst_issued", stat_issued_o, 0);
    chk("rst_completed", stat_completed_o, 0);
    chk("rst_lat_sum", stat_lat_sum_o, 0);
    chk("rst_lat_max", stat_lat_max_o, 0);
    chk("rst_stall", stat_stall_o, 0);

    // T2 hotspot, 4 reads, 1-cycle responses
    cfg_mode_i = 2'd2; cfg_base_addr_i = 32'h100; cfg_rate_i = 8'd255; cfg_num_req_i = 4;
    start_run();
    chk("t2_busy", busy_o, 1'b1);
    run_cycles(100, 1'b1, 1'b1);
    chk("t2_hs_cnt", hs_cnt, 4);
    chk("t2_issued", stat_issued_o, 4);
    chk("t2_completed", stat_completed_o, 4);
    chk("t2_lat_max", stat_lat_max_o, 1);
    chk("t2_lat_sum", stat_lat_sum_o, 4);
    chk("t2_stall", stat_stall_o, 0);
    chk("t2_busy_end", busy_o, 1'b0);
    chk("t2_err", err_o, 1'b0);

    // T3 sequential writes with offset wrap
    cfg_mode_i = 2'd1; cfg_base_addr_i = 32'h0; cfg_stride_i = 32'h4; cfg_addr_mask_i = 32'hFF;
    cfg_num_req_i = 70; cfg_wen_i = 1'b1;
    start_run();
    run_cycles(400, 1'b1, 1'b1);
    chk("t3_hs_cnt", hs_cnt, 70);
    chk("t3_issued", stat_issued_o, 70);
    chk("t3_completed", stat_completed_o, 70);
    chk("t3_lat_max", stat_lat_max_o, 1);

    // T4 backpressure then ID exhaustion (random mode, reads, no responses)
    cfg_mode_i = 2'd0; cfg_base_addr_i = 32'h1000; cfg_addr_mask_i = 32'hFFC;
    cfg_num_req_i = 0; cfg_wen_i = 1'b0; bus.req_ready = 1'b0;
    start_run();
    for (int i = 0; i < 50; i++) begin
      if (bus.req_valid) break;
      tick();
    end
    chk("t4_valid_rise", bus.req_valid, 1'b1);
    cap_addr = bus.req_addr; cap_wdata = bus.req_wdata; cap_id = bus.req_id;
    chk("t4_first_id", cap_id, 0);
    chk("t4_region", cap_addr & ~cfg_addr_mask_i, cfg_base_addr_i);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", bus.req_valid, 1'b1);
      chk("t4_hold_addr", bus.req_addr, cap_addr);
      chk("t4_hold_wdata", bus.req_wdata, cap_wdata);
      chk("t4_hold_id", bus.req_id, cap_id);
    end
    bus.req_ready = 1'b1;
    run_cycles(100, 1'b0, 1'b0);
    chk("t4_stall", stat_stall_o, 10);
    chk("t4_issued", stat_issued_o, 8);
    chk("t4_hs_cnt", hs_cnt, 8);
    chk("t4_all_ids", tb_out, 8'hFF);
    chk("t4_halted", bus.req_valid, 1'b0);
    chk("t4_busy", busy_o, 1'b1);
    chk("t4_completed", stat_completed_o, 0);

    // T5 unknown-ID response, then stop and drain
    cfg_rate_i = 8'd0;
    tick();
    bus.resp_valid = 1'b1; bus.resp_id = 3'd3;
    tick();
    bus.resp_valid = 1'b0;
    chk("t5_completed_1", stat_completed_o, 1);
    chk("t5_err_clean", err_o, 1'b0);
    bus.resp_valid = 1'b1; bus.resp_id = 3'd3;
    tick();
    bus.resp_valid = 1'b0;
    chk("t5_err_set", err_o, 1'b1);
    chk("t5_completed_same", stat_completed_o, 1);
    tick();
    chk("t5_err_sticky", err_o, 1'b1);
    chk("t5_no_reissue", bus.req_valid, 1'b0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t5_drain_busy", busy_o, 1'b1);
    chk("t5_drain_done", done_o, 1'b0);
    drain_ids = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 7; i++) begin
      bus.resp_valid = 1'b1; bus.resp_id = drain_ids[i];
      tick();
    end
    bus.resp_valid = 1'b0;
    chk("t5_not_done_yet", done_o, 1'b0);
    tick();
    chk("t5_done", done_o, 1'b1);
    chk("t5_busy_end", busy_o, 1'b0);
    chk("t5_completed_all", stat_completed_o, 8);
    chk("t5_err_kept", err_o, 1'b1);

    // T6 rate 0, reset mid-run, stale response after restart
    cfg_mode_i = 2'd2; cfg_base_addr_i = 32'h100; cfg_rate_i = 8'd0; cfg_num_req_i = 0;
    start_run();
    chk("t6_err_cleared", err_o, 1'b0);
    chk("t6_completed_cleared", stat_completed_o, 0);
    chk("t6_stall_cleared", stat_stall_o, 0);
    vcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.req_valid) vcnt++;
      tick();
    end
    chk("t6_no_req", vcnt, 0);
    chk("t6_issued", stat_issued_o, 0);
    cfg_rate_i = 8'd255; bus.req_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_valid_before_rst", bus.req_valid, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_rst_valid", bus.req_valid, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_done", done_o, 1'b0);
    chk("t6_rst_stall", stat_stall_o, 0);
    chk("t6_rst_resp_ready", bus.resp_ready, 1'b1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t6_stop_idle_busy", busy_o, 1'b0);
    chk("t6_stop_idle_done", done_o, 1'b0);
    bus.req_ready = 1'b1; cfg_rate_i = 8'd0;
    start_run();
    bus.resp_valid = 1'b1; bus.resp_id = 3'd0;
    tick();
    bus.resp_valid = 1'b0;
    chk("t6_stale_err", err_o, 1'b1);
    chk("t6_stale_completed", stat_completed_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
